bg_tile_generator: RTL and testbench

- Parametrised successor to the fixed-map Pong background tile source.
- Maps a tile coordinate (column, row) to a tile index that feeds the tile ROM / pixel pipeline.
- Supports four modes: static border bands, solid fill, checkerboard, and animated (scrolling) border bands.
- Mode and scroll state change only on frame boundaries, so a frame never tears mid-scan.

---
 rtl/bg_tile_generator.sv | 168 ++++++++++++++++
 tb/tb_bg_tile_generator.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bg_tile_generator.sv
// Background tile source: maps a (column, row) tile coordinate to a tile index
// through a fixed 2-cycle pipeline, with frame-synchronous mode and scroll updates.
module bg_tile_generator #(
  parameter int COLS        = 120,
  parameter int ROWS        = 68,
  parameter int COL_W       = 7,
  parameter int ROW_W       = 7,
  parameter int DATA_W      = 6,
  parameter int BORDER_ROWS = 4,
  parameter int BORDER_BASE = 6,
  parameter int FILL_TILE   = 12,
  parameter int CHECK_TILE  = 13,
  parameter int CHECK_LOG2  = 2,
  parameter int SCROLL_DIV  = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_frame_start,
  input  logic [1:0]        i_bg_set,
  input  logic              i_valid,
  input  logic [COL_W-1:0]  i_col,
  input  logic [ROW_W-1:0]  i_row,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_oob
);

  // Handshake: a request is taken whenever i_valid is high (no backpressure);
  // o_valid pulses exactly two cycles later and qualifies o_data and o_oob.

  localparam int FC_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(SCROLL_DIV - 1);

  typedef enum logic [1:0] {CLS_TOP, CLS_BOT, CLS_MID, CLS_OOB} band_e;

  // Frame-synchronous settings
  logic [1:0]      mode_q;
  logic [1:0]      scroll_q;
  logic [FC_W-1:0] fc_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      mode_q   <= 2'd0;
      scroll_q <= 2'd0;
      fc_q     <= '0;
    end else if (i_frame_start) begin
      mode_q <= i_bg_set;
      if (i_bg_set == 2'd3) begin
        if (fc_q == FC_LAST) begin
          fc_q     <= '0;
          scroll_q <= scroll_q + 2'd1;
        end else begin
          fc_q <= fc_q + FC_W'(1);
        end
      end else begin
        fc_q     <= '0;
        scroll_q <= 2'd0;
      end
    end
  end

  // Stage 1: classify the coordinate
  logic [31:0] col_ext, row_ext;
  band_e       cls_d;
  logic [1:0]  k_d, p_d, scroll_eff;
  logic        chk_d;

  assign col_ext = 32'(i_col);
  assign row_ext = 32'(i_row);

  always_comb begin
    cls_d      = CLS_MID;
    k_d        = 2'd0;
    scroll_eff = (mode_q == 2'd3) ? scroll_q : 2'd0;
    p_d        = i_col[1:0] + scroll_eff;
    chk_d      = i_col[CHECK_LOG2] ^ i_row[CHECK_LOG2];
    if (col_ext >= 32'(COLS) || row_ext >= 32'(ROWS)) begin
      cls_d = CLS_OOB;
    end else if (row_ext < 32'(BORDER_ROWS)) begin
      cls_d = CLS_TOP;
      k_d   = i_row[1:0];
    end else if (row_ext >= 32'(ROWS - BORDER_ROWS)) begin
      cls_d = CLS_BOT;
      // Bottom band starts two rows into the pattern so it mirrors the top.
      k_d   = i_row[1:0] - 2'(ROWS - BORDER_ROWS) + 2'd2;
    end
  end

  logic       v1;
  band_e      cls1;
  logic [1:0] k1, p1, mode1;
  logic       chk1;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      v1    <= 1'b0;
      cls1  <= CLS_MID;
      k1    <= 2'd0;
      p1    <= 2'd0;
      chk1  <= 1'b0;
      mode1 <= 2'd0;
    end else begin
      v1 <= i_valid;
      if (i_valid) begin
        cls1  <= cls_d;
        k1    <= k_d;
        p1    <= p_d;
        chk1  <= chk_d;
        mode1 <= mode_q;
      end
    end
  end

  // Stage 2: tile selection
  function automatic logic [2:0] border_off(input logic hi, input logic [1:0] p);
    logic [2:0] r;
    if (hi) begin
      case (p)
        2'd0:    r = 3'd0;
        2'd1:    r = 3'd2;
        2'd2:    r = 3'd2;
        default: r = 3'd4;
      endcase
    end else begin
      case (p)
        2'd0:    r = 3'd2;
        2'd1:    r = 3'd4;
        2'd2:    r = 3'd0;
        default: r = 3'd2;
      endcase
    end
    return r;
  endfunction

  logic [DATA_W-1:0] border_tile, sel_d;
  logic              oob_d;

  assign border_tile = DATA_W'(BORDER_BASE) + DATA_W'(border_off(k1[1], p1)) + DATA_W'(k1[0]);

  always_comb begin
    sel_d = DATA_W'(FILL_TILE);
    oob_d = 1'b0;
    if (cls1 == CLS_OOB) begin
      oob_d = 1'b1;
    end else begin
      case (mode1)
        2'd1:    sel_d = DATA_W'(FILL_TILE);
        2'd2:    sel_d = chk1 ? DATA_W'(CHECK_TILE) : DATA_W'(FILL_TILE);
        default: sel_d = (cls1 == CLS_MID) ? DATA_W'(FILL_TILE) : border_tile;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_oob   <= 1'b0;
    end else begin
      o_valid <= v1;
      if (v1) begin
        o_data <= sel_d;
        o_oob  <= oob_d;
      end
    end
  end

endmodule

// File: tb/tb_bg_tile_generator.sv
// Scoreboard bench for bg_tile_generator: directed scenarios then random traffic,
// checked against an arithmetic reference of the tile rules.
module tb_bg_tile_generator;

  localparam int COLS        = 120;
  localparam int ROWS        = 68;
  localparam int COL_W       = 7;
  localparam int ROW_W       = 7;
  localparam int DATA_W      = 6;
  localparam int BORDER_ROWS = 4;
  localparam int BORDER_BASE = 6;
  localparam int FILL_TILE   = 12;
  localparam int CHECK_TILE  = 13;
  localparam int CHECK_LOG2  = 2;
  localparam int SCROLL_DIV  = 2;
  localparam int W           = DATA_W + 1;

  logic              i_clk = 1'b0;
  logic              i_reset = 1'b1;
  logic              i_frame_start = 1'b0;
  logic [1:0]        i_bg_set = 2'd0;
  logic              i_valid = 1'b0;
  logic [COL_W-1:0]  i_col = '0;
  logic [ROW_W-1:0]  i_row = '0;
  logic              o_valid;
  logic [DATA_W-1:0] o_data;
  logic              o_oob;

  bg_tile_generator #(
    .COLS(COLS), .ROWS(ROWS), .COL_W(COL_W), .ROW_W(ROW_W), .DATA_W(DATA_W),
    .BORDER_ROWS(BORDER_ROWS), .BORDER_BASE(BORDER_BASE), .FILL_TILE(FILL_TILE),
    .CHECK_TILE(CHECK_TILE), .CHECK_LOG2(CHECK_LOG2), .SCROLL_DIV(SCROLL_DIV)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_frame_start(i_frame_start),
    .i_bg_set(i_bg_set), .i_valid(i_valid), .i_col(i_col), .i_row(i_row),
    .o_valid(o_valid), .o_data(o_data), .o_oob(o_oob)
  );

  // Clock
  always #5 i_clk = ~i_clk;

  // Reference state: mode and count of consecutive mode-3 frame starts
  int m_mode = 0;
  int m_n    = 0;
  int tests  = 0;
  int fails  = 0;
  int quiet  = 0;
  logic [W-1:0] exp_q[$];

  int tab_a[4] = '{2, 4, 0, 2};
  int tab_b[4] = '{0, 2, 2, 4};

  function automatic logic [W-1:0] ref_tile(input int col, input int row);
    int scroll, p, k, t;
    if (col >= COLS || row >= ROWS) return {1'b1, DATA_W'(FILL_TILE)};
    if (m_mode == 1) return {1'b0, DATA_W'(FILL_TILE)};
    if (m_mode == 2) begin
      t = (((col >> CHECK_LOG2) ^ (row >> CHECK_LOG2)) & 1) ? CHECK_TILE : FILL_TILE;
      return {1'b0, DATA_W'(t)};
    end
    scroll = (m_mode == 3) ? (m_n / SCROLL_DIV) % 4 : 0;
    p = (col + scroll) % 4;
    if (row < BORDER_ROWS) k = row % 4;
    else if (row >= ROWS - BORDER_ROWS) k = (row - (ROWS - BORDER_ROWS) + 2) % 4;
    else return {1'b0, DATA_W'(FILL_TILE)};
    t = BORDER_BASE + ((k >= 2) ? tab_b[p] : tab_a[p]) + (k % 2);
    return {1'b0, DATA_W'(t)};
  endfunction

  // Driver: one clock cycle of stimulus, inputs change just after posedge
  task automatic drive_cycle(input bit v, input int col, input int row,
                             input bit fs, input int mode, input bit rst);
    i_valid       = v;
    i_col         = COL_W'(col);
    i_row         = ROW_W'(row);
    i_frame_start = fs;
    i_bg_set      = fs ? 2'(mode) : 2'($urandom_range(0, 3));
    i_reset       = rst;
    if (rst) begin
      m_mode = 0;
      m_n    = 0;
    end else begin
      if (v) exp_q.push_back(ref_tile(col, row));
      if (fs) begin
        m_mode = mode;
        m_n    = (mode == 3) ? m_n + 1 : 0;
      end
    end
    @(posedge i_clk);
    #1;
    if (rst) begin
      exp_q.delete();
      quiet = 2;
    end
  endtask

  task automatic req(input int col, input int row);
    drive_cycle(1'b1, col, row, 1'b0, 0, 1'b0);
  endtask

  task automatic frame(input int mode);
    drive_cycle(1'b0, 0, 0, 1'b1, mode, 1'b0);
  endtask

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result
  always @(negedge i_clk) begin
    logic [W-1:0] e;
    if (quiet > 0) begin
      check("quiet_after_reset", int'(o_valid), 0);
      quiet--;
    end else if (o_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        tests++;
        if ({o_oob, o_data} !== e) begin
          fails++;
          $display("FAIL tile: got oob=%0d data=%0d, want oob=%0d data=%0d",
                   o_oob, o_data, e[W-1], e[DATA_W-1:0]);
        end
      end
    end
  end

  initial begin
    int col, row;
    // Reset and reset-state check
    repeat (3) drive_cycle(1'b0, 0, 0, 1'b0, 0, 1'b1);
    @(negedge i_clk);
    check("reset_valid", int'(o_valid), 0);
    check("reset_data", int'(o_data), 0);
    check("reset_oob", int'(o_oob), 0);

    // Mode 0 borders, interior and out-of-range
    frame(0);
    for (int c = 0; c < 4; c++) req(c, 0);
    req(1, 3); req(1, 64); req(1, 67); req(0, 4); req(0, 63);
    req(120, 0); req(0, 68);

    // Checkerboard and solid fill
    frame(2);
    req(0, 0); req(4, 0); req(4, 4); req(9, 30);
    frame(1);
    req(5, 30); req(77, 2);

    // Scrolling, then return to static borders
    for (int f = 0; f < 4; f++) begin
      frame(3);
      req(0, 0);
    end
    frame(0);
    req(0, 0);
    repeat (3) drive_cycle(1'b0, 0, 0, 1'b0, 0, 1'b0);

    // Back-to-back burst with a frame start and a reset inside it
    for (int i = 0; i < 10; i++)
      drive_cycle(1'b1, i, 1, i == 5, 2, i == 8);
    repeat (3) drive_cycle(1'b0, 0, 0, 1'b0, 0, 1'b0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      col = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 8);
      case ($urandom_range(0, 2))
        0:       row = $urandom_range(0, 5);
        1:       row = $urandom_range(62, 70);
        default: row = $urandom_range(0, 127);
      endcase
      drive_cycle($urandom_range(0, 3) != 0, col, row,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 3), 1'b0);
    end

    // Drain with a bounded wait
    repeat (4) drive_cycle(1'b0, 0, 0, 1'b0, 0, 1'b0);
    @(negedge i_clk);
    check("drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
